crop_stride_filter: RTL
=======================

# crop_stride_filter

Streaming crop and decimate stage for the pixel pipeline. It takes a raster-ordered pixel stream of up to MAX_ROWS×MAX_COLS, and passes on the pixels inside a crop window set at run time, subsampled by independent X/Y strides. It adds start-of-frame, end-of-line and end-of-frame sidebands, and a registered 2-entry output buffer so that `in_ready` has no combinational path from `out_ready`. It sits where the fixed-window crop sat: between the sensor unpacker and the downstream ROI consumers.

## Interface
- PIXEL_BIT_WIDTH, 12: pixel width.
- MAX_ROWS, 1024: largest supported input height.
- MAX_COLS, 1024: largest supported input width.
- STRIDE_BITS, 4: width of the stride config fields.
- Coordinate widths: CW = $clog2(MAX_COLS+1), RW = $clog2(MAX_ROWS+1).

Clock, reset and stream ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pixel_in  in  PIXEL_BIT_WIDTH  input pixel.
- in_valid  in  1  input pixel valid.
- in_sof  in  1  input start-of-frame. Qualified by in_valid; forces the current pixel to (0,0).
- in_ready  out  1  block can accept a pixel. Driven from a register only.
- pixel_out  out  PIXEL_BIT_WIDTH  output pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream can accept.
- out_sof / out_eol / out_eof  out  1 each  first pixel of the output frame / last pixel of an output row / last pixel of the output frame.

Config ports (quasi-static):
- cfg_in_rows, cfg_in_cols  in  RW / CW  input frame size. Must be ≥1.
- cfg_y1, cfg_x1  in  RW / CW  top-left corner of the crop.
- cfg_out_rows, cfg_out_cols  in  RW / CW  crop height and width.
- cfg_stride_y, cfg_stride_x  in  STRIDE_BITS  decimation factors. A value of 0 is treated as 1.

## Operation
- **Config shadowing:** all cfg_* are copied into shadow registers on reset and at every frame boundary. A frame boundary is the accept of the last input pixel of a frame, or an accept with in_sof=1. Mid-frame changes to cfg_* have no effect until the next boundary.
- **Accept:** a pixel is accepted on a cycle with in_valid & in_ready. Every accepted pixel advances (x,y), whether or not it passes.
  - x wraps at cfg_in_cols-1.
  - y wraps at cfg_in_rows-1.
  - If in_sof=1 on the accept, that pixel is treated as (0,0) and the next pixel is (1,0).
- **Pass rule:** a pixel passes iff all of:
  - y1 ≤ y < y1+out_rows;
  - x1 ≤ x < x1+out_cols;
  - phase_y == 0 and phase_x == 0.
- **Phase counters:**
  - phase_x resets to 0 at x == x1, increments per accepted pixel, and wraps at stride_x-1.
  - phase_y resets to 0 at y == y1, increments per row start, and wraps at stride_y-1.
- **Width rule:** window sums (x1+out_cols, x+stride_x, etc.) are computed at CW+1 / RW+1 bits, so there is no overflow. A window that extends past the frame is simply clipped. out_rows or out_cols == 0 means no output.
- **Sidebands for a passing pixel:**
  - eol = (x+stride_x ≥ x1+out_cols).
  - eof = eol & (y+stride_y ≥ y1+out_rows).
  - sof = first passing pixel since the last frame boundary.
- **Buffer:** passing pixels, together with their sidebands, go into the 2-entry buffer. Non-passing pixels are accepted and dropped.
  - in_ready = (count != 2).
  - The head of the buffer drives pixel_out/out_*.
  - out_valid = (count != 0).
- **Reset values:**
  - out_valid=0, out_sof/eol/eof=0, pixel_out=0.
  - in_ready=0 during reset, 1 the cycle after.
  - Buffer empty, x=y=0, phases=0, sof pending.
- **Reset mid-frame:** buffered pixels are discarded and the coordinates return to (0,0). The stream resynchronises on the next in_sof or at the natural (0,0).

## Timing
- Latency: an accepted passing pixel appears on out_valid the next cycle, if the buffer was empty.
- Sustained 1 pixel/cycle while out_ready=1.
- out_valid/pixel_out/sidebands are held stable until out_ready=1. There is no retraction.
- Simultaneous push and pop at count==2 is impossible, because in_ready=0. At count==1, a push and a pop in the same cycle keep count==1.
- After out_ready drops, in_ready drops within 2 accepts; no data is lost.

## Structure
- Shared package crop_pkg holds:
  - the coordinate width helpers (CW, RW);
  - the packed sideband struct {sof, eol, eof, pixel};
  - the stride-of-0→1 normalisation function.
- Sub-module crop_skid_buffer: a 2-entry valid/ready buffer, parametrised on data width, used for the output stage. The counter, phase and pass logic stay in crop_stride_filter.

## Test plan
- **Basic crop:** 8×8 frame, x1=y1=2, out 4×4, stride 1, out_ready=1 → 16 pixels, values = raster indices 18..21, 26..29, 34..37, 42..45. eol on 21/29/37/45, sof on 18, eof on 45.
- **Stride:** 8×8 frame, x1=y1=1, out 6×6, stride_x=2, stride_y=3 → pixels 9, 11, 13, 33, 35, 37. eol on 13 and 37, eof on 37.
- **Backpressure:** basic crop with out_ready toggling 1-0-0-1 → identical output sequence, in_ready low only while count==2, no pixel held longer than the stall.
- **Clipping and empty window:**
  - x1=6, out_cols=4 on an 8-wide frame → only x=6,7 pass, and eol is on x=7.
  - out_rows=0 → no out_valid for the whole frame.
- **Config shadowing and in_sof:**
  - Change cfg_x1 mid-frame → applied only from the next frame.
  - in_sof asserted at raster index 5 → that pixel is treated as (0,0), and the following output matches a fresh frame.
- **Reset mid-frame:** assert reset with 2 pixels buffered → the next cycle has out_valid=0, and the next frame's output is correct from sof.

Source files
------------

// File: rtl/crop_pkg.sv
// crop_pkg: shared types and helpers for the crop/stride filter
package crop_pkg;
    localparam int PIX_W = 12;
    localparam int STR_W = 4;
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
        logic [PIX_W-1:0] pixel;
    } side_t;
    function automatic int coord_w(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction
    function automatic logic [STR_W-1:0] norm_stride(input logic [STR_W-1:0] s);
        return (s == '0) ? STR_W'(1) : s;
    endfunction
endpackage

// File: rtl/crop_stride_filter_if.sv
// crop_stride_filter_if: pixel stream in/out handshake bundle
interface crop_stride_filter_if #(parameter int PIXEL_BIT_WIDTH = 12);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic in_valid, in_sof, in_ready;
    logic out_valid, out_ready, out_sof, out_eol, out_eof;
    modport master(output pixel_in, in_valid, in_sof, out_ready,
                   input in_ready, pixel_out, out_valid, out_sof, out_eol, out_eof);
    modport slave(input pixel_in, in_valid, in_sof, out_ready,
                  output in_ready, pixel_out, out_valid, out_sof, out_eol, out_eof);
endinterface

// File: rtl/crop_skid_buffer.sv
// crop_skid_buffer: 2-entry valid/ready FIFO with a registered in_ready
module crop_skid_buffer #(parameter int W = 8) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_push,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] mem [2];
    logic rd, wr, push, pop;
    logic [1:0] count, count_n;
    always_comb begin
        push = in_push && in_ready;
        pop = out_valid && out_ready;
        count_n = count + {1'b0, push} - {1'b0, pop};
    end
    assign out_valid = count != 2'd0;
    assign out_data = mem[rd];
    // in_ready looks ahead at the next count so it never depends on out_ready combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd <= 1'b0;
            wr <= 1'b0;
            count <= '0;
            in_ready <= 1'b0;
        end else begin
            count <= count_n;
            in_ready <= count_n != 2'd2;
            if (push) begin
                mem[wr] <= in_data;
                wr <= !wr;
            end
            if (pop) rd <= !rd;
        end
    end
endmodule

// File: rtl/crop_stride_filter.sv
// crop_stride_filter: run-time crop window with X/Y decimation and frame sidebands
module crop_stride_filter
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = PIX_W,
    parameter int MAX_ROWS = 1024,
    parameter int MAX_COLS = 1024,
    parameter int STRIDE_BITS = STR_W,
    localparam int CW = coord_w(MAX_COLS),
    localparam int RW = coord_w(MAX_ROWS)
) (
    input logic clk,
    input logic reset,
    crop_stride_filter_if.slave s,
    input logic [RW-1:0] cfg_in_rows,
    input logic [CW-1:0] cfg_in_cols,
    input logic [RW-1:0] cfg_y1,
    input logic [CW-1:0] cfg_x1,
    input logic [RW-1:0] cfg_out_rows,
    input logic [CW-1:0] cfg_out_cols,
    input logic [STRIDE_BITS-1:0] cfg_stride_y,
    input logic [STRIDE_BITS-1:0] cfg_stride_x
);
    typedef struct packed {
        logic [RW-1:0] in_rows, y1, out_rows;
        logic [CW-1:0] in_cols, x1, out_cols;
        logic [STR_W-1:0] sy, sx;
    } cfg_t;
    cfg_t cfg_in, sh, e;
    side_t push_d, head;
    logic [PIXEL_BIT_WIDTH-1:0] pix;
    logic [CW-1:0] x, cx;
    logic [RW-1:0] y, cy;
    logic [STR_W-1:0] phase_x, phase_y, px, py;
    logic [CW:0] xs, x_end;
    logic [RW:0] ys, y_end;
    logic sof_pend, eff_pend, acc, pass, eol, eof, last_col, last_row, push;
    // an in_sof pixel starts a new frame, so it already sees the live config
    always_comb begin
        cfg_in = '{cfg_in_rows, cfg_y1, cfg_out_rows, cfg_in_cols, cfg_x1, cfg_out_cols,
                   norm_stride(cfg_stride_y), norm_stride(cfg_stride_x)};
        e = s.in_sof ? cfg_in : sh;
        cx = s.in_sof ? '0 : x;
        cy = s.in_sof ? '0 : y;
        px = (cx == e.x1) ? '0 : phase_x;
        py = (cy == e.y1) ? '0 : phase_y;
        xs = {1'b0, e.x1} + {1'b0, e.out_cols};
        ys = {1'b0, e.y1} + {1'b0, e.out_rows};
        x_end = (xs < {1'b0, e.in_cols}) ? xs : {1'b0, e.in_cols};
        y_end = (ys < {1'b0, e.in_rows}) ? ys : {1'b0, e.in_rows};
        pass = cx >= e.x1 && {1'b0, cx} < x_end && cy >= e.y1 && {1'b0, cy} < y_end
               && px == '0 && py == '0;
        eol = {1'b0, cx} + (CW+1)'(e.sx) >= x_end;
        eof = eol && {1'b0, cy} + (RW+1)'(e.sy) >= y_end;
        last_col = cx == e.in_cols - CW'(1);
        last_row = cy == e.in_rows - RW'(1);
        acc = s.in_valid && s.in_ready;
        eff_pend = s.in_sof || sof_pend;
        push = acc && pass;
        pix = s.pixel_in;
        push_d = '{eff_pend, eol, eof, pix};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sh <= cfg_in;
            x <= '0;
            y <= '0;
            phase_x <= '0;
            phase_y <= '0;
            sof_pend <= 1'b1;
        end else begin
            if (acc && (s.in_sof || (last_col && last_row))) sh <= cfg_in;
            if (acc) begin
                x <= last_col ? '0 : cx + CW'(1);
                y <= !last_col ? cy : last_row ? '0 : cy + RW'(1);
                phase_x <= (px == e.sx - STR_W'(1)) ? '0 : px + STR_W'(1);
                phase_y <= !last_col ? phase_y : (py == e.sy - STR_W'(1)) ? '0 : py + STR_W'(1);
                sof_pend <= (last_col && last_row) || (eff_pend && !pass);
            end
        end
    end
    crop_skid_buffer #(.W($bits(side_t))) u_buf (
        .clk(clk),
        .reset(reset),
        .in_data(push_d),
        .in_push(push),
        .in_ready(s.in_ready),
        .out_data(head),
        .out_valid(s.out_valid),
        .out_ready(s.out_ready)
    );
    assign s.pixel_out = head.pixel;
    assign s.out_sof = head.sof;
    assign s.out_eol = head.eol;
    assign s.out_eof = head.eof;
endmodule
